// File: rtl/gen_fip_inner_prod_arb.sv
// Round-robin arbiter that shares one pipelined inner-product engine and tags its results with requester IDs.
// Optional macro GEN_FIP_IP_ARB_STATS_EN adds saturating per-requester grant counters on o_gnt_cnt.
module gen_fip_inner_prod_arb #(
  parameter int  NUM_REQ       = 4,
  parameter int  VEC_ELEMS_NUM = 32,
  parameter int  ONE_ELEM_W    = 6,
  parameter int  RES_W         = 43,
  parameter int  MAX_OUT       = 8,
  parameter int  SIM_DLY       = 1,
  localparam int ID_W          = $clog2(NUM_REQ),
  localparam int VEC_W         = VEC_ELEMS_NUM * ONE_ELEM_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sw_rst,
  input  logic [NUM_REQ-1:0]       i_req_vld,
  input  logic [NUM_REQ*VEC_W-1:0] i_req_vec1,
  input  logic [NUM_REQ*VEC_W-1:0] i_req_vec2,
  output logic [NUM_REQ-1:0]       o_req_gnt,
  output logic                     o_eng_valid_pls,
  output logic [VEC_W-1:0]         o_eng_vec1,
  output logic [VEC_W-1:0]         o_eng_vec2,
  input  logic                     i_eng_valid_pls,
  input  logic [RES_W-1:0]         i_eng_res,
  output logic                     o_res_valid_pls,
  output logic [RES_W-1:0]         o_res,
  output logic [ID_W-1:0]          o_res_id,
  output logic                     o_busy,
`ifdef GEN_FIP_IP_ARB_STATS_EN
  output logic [NUM_REQ*16-1:0]    o_gnt_cnt,
`endif
  output logic                     o_err
);

  localparam int              PTR_W   = $clog2(MAX_OUT);
  localparam int              CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
  localparam logic [ID_W-1:0]  PTR_RST = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [ID_W-1:0]  fifo_q [MAX_OUT];
  logic [ID_W-1:0]  fifo_d [MAX_OUT];
  logic             eng_valid_q, eng_valid_d;
  logic [VEC_W-1:0] eng_vec1_q, eng_vec1_d, eng_vec2_q, eng_vec2_d;
  logic             res_valid_q, res_valid_d;
  logic [RES_W-1:0] res_q, res_d;
  logic [ID_W-1:0]  res_id_q, res_id_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic               can_issue_s, hit_s, issue_s, pop_s, spurious_s;
  logic [ID_W-1:0]    gnt_id_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic               unused_sim_dly_s;

  assign unused_sim_dly_s = (SIM_DLY != 0);

  // Round-robin search from pointer+1; grant is blocked while any reset is active.
  always_comb begin
    can_issue_s = (cnt_q < MAX_CNT);
    hit_s       = 1'b0;
    gnt_id_s    = ptr_q;
    gnt_s       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!hit_s && i_req_vld[(int'(ptr_q) + i) % NUM_REQ]) begin
        hit_s    = 1'b1;
        gnt_id_s = ID_W'((int'(ptr_q) + i) % NUM_REQ);
      end else begin
        hit_s    = hit_s;
      end
    end
    issue_s    = hit_s && can_issue_s && !sw_rst && !rst;
    pop_s      = i_eng_valid_pls && (cnt_q != '0);
    spurious_s = i_eng_valid_pls && (cnt_q == '0);
    if (issue_s) begin
      gnt_s[gnt_id_s] = 1'b1;
    end else begin
      gnt_s = '0;
    end
  end

  // Next-state: issue register, ID FIFO, outstanding count, tagged result and error flag.
  always_comb begin
    fifo_d      = fifo_q;
    eng_valid_d = 1'b0;
    res_valid_d = 1'b0;
    if (sw_rst) begin
      ptr_d      = PTR_RST;
      cnt_d      = '0;
      wr_d       = '0;
      rd_d       = '0;
      eng_vec1_d = '0;
      eng_vec2_d = '0;
      res_d      = '0;
      res_id_d   = '0;
      busy_d     = 1'b0;
      err_d      = 1'b0;
    end else begin
      if (issue_s) begin
        ptr_d          = gnt_id_s;
        fifo_d[wr_q]   = gnt_id_s;
        wr_d           = wr_q + PTR_W'(1);
        eng_valid_d    = 1'b1;
        eng_vec1_d     = i_req_vec1[gnt_id_s*VEC_W +: VEC_W];
        eng_vec2_d     = i_req_vec2[gnt_id_s*VEC_W +: VEC_W];
      end else begin
        ptr_d      = ptr_q;
        wr_d       = wr_q;
        eng_vec1_d = eng_vec1_q;
        eng_vec2_d = eng_vec2_q;
      end
      if (pop_s) begin
        rd_d        = rd_q + PTR_W'(1);
        res_valid_d = 1'b1;
        res_d       = i_eng_res;
        res_id_d    = fifo_q[rd_q];
      end else begin
        rd_d     = rd_q;
        res_d    = res_q;
        res_id_d = res_id_q;
      end
      case ({issue_s, pop_s})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
      busy_d = (cnt_d != '0);
      err_d  = err_q | spurious_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= PTR_RST;
      cnt_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      fifo_q      <= '{default: '0};
      eng_valid_q <= 1'b0;
      eng_vec1_q  <= '0;
      eng_vec2_q  <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      res_id_q    <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      fifo_q      <= fifo_d;
      eng_valid_q <= eng_valid_d;
      eng_vec1_q  <= eng_vec1_d;
      eng_vec2_q  <= eng_vec2_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
      res_id_q    <= res_id_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign o_req_gnt       = gnt_s;
  assign o_eng_valid_pls = eng_valid_q;
  assign o_eng_vec1      = eng_vec1_q;
  assign o_eng_vec2      = eng_vec2_q;
  assign o_res_valid_pls = res_valid_q;
  assign o_res           = res_q;
  assign o_res_id        = res_id_q;
  assign o_busy          = busy_q;
  assign o_err           = err_q;

`ifdef GEN_FIP_IP_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] gnt_cnt_q, gnt_cnt_d;

  // Saturating grant counter per requester.
  always_comb begin
    gnt_cnt_d = gnt_cnt_q;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (sw_rst) begin
        gnt_cnt_d[r*16 +: 16] = 16'h0000;
      end else if (gnt_s[r] && (gnt_cnt_q[r*16 +: 16] != 16'hFFFF)) begin
        gnt_cnt_d[r*16 +: 16] = gnt_cnt_q[r*16 +: 16] + 16'h0001;
      end else begin
        gnt_cnt_d[r*16 +: 16] = gnt_cnt_q[r*16 +: 16];
      end
    end
  end

  // Grant counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt_q <= '0;
    end else begin
      gnt_cnt_q <= gnt_cnt_d;
    end
  end

  assign o_gnt_cnt = gnt_cnt_q;
`endif

endmodule

// File: tb/tb_gen_fip_inner_prod_arb.sv
// Bench for gen_fip_inner_prod_arb: behavioural engine stub, queue-based reference model and directed/random tests.
module tb_gen_fip_inner_prod_arb;
  localparam int NUM_REQ = 4;
  localparam int ELEMS   = 32;
  localparam int EW      = 6;
  localparam int VEC_W   = ELEMS * EW;
  localparam int RES_W   = 43;
  localparam int MAX_OUT = 8;
  localparam int ID_W    = 2;
  localparam int LAT     = 7;

  logic clk = 1'b0;
  logic rst, sw_rst;
  logic [NUM_REQ-1:0]       vld;
  logic [NUM_REQ*VEC_W-1:0] v1, v2;
  logic [NUM_REQ-1:0]       o_req_gnt;
  logic                     o_eng_valid_pls;
  logic [VEC_W-1:0]         o_eng_vec1, o_eng_vec2;
  logic                     eng_vld;
  logic [RES_W-1:0]         eng_res;
  logic                     o_res_valid_pls;
  logic [RES_W-1:0]         o_res;
  logic [ID_W-1:0]          o_res_id;
  logic                     o_busy, o_err;
`ifdef GEN_FIP_IP_ARB_STATS_EN
  logic [NUM_REQ*16-1:0]    gnt_cnt;
`endif

  logic             eng_on, inj;
  logic [RES_W-1:0] inj_res;
  int n_pass = 0;
  int n_tot  = 0;
  int cyc_n  = 0;

  gen_fip_inner_prod_arb dut (
    .clk(clk), .rst(rst), .sw_rst(sw_rst),
    .i_req_vld(vld), .i_req_vec1(v1), .i_req_vec2(v2),
    .o_req_gnt(o_req_gnt), .o_eng_valid_pls(o_eng_valid_pls),
    .o_eng_vec1(o_eng_vec1), .o_eng_vec2(o_eng_vec2),
    .i_eng_valid_pls(eng_vld), .i_eng_res(eng_res),
    .o_res_valid_pls(o_res_valid_pls), .o_res(o_res), .o_res_id(o_res_id),
    .o_busy(o_busy),
`ifdef GEN_FIP_IP_ARB_STATS_EN
    .o_gnt_cnt(gnt_cnt),
`endif
    .o_err(o_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [RES_W-1:0] dot(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
    longint s = 0;
    for (int e = 0; e < ELEMS; e++)
      s += longint'($signed(a[e*EW +: EW])) * longint'($signed(b[e*EW +: EW]));
    return s[RES_W-1:0];
  endfunction

  // Engine stub: fixed-latency dot product, cleared with the arbiter's resets
  logic             pv [LAT];
  logic [RES_W-1:0] pr [LAT];
  always @(posedge clk) begin
    if (rst || sw_rst) begin
      for (int k = 0; k < LAT; k++) begin pv[k] <= 1'b0; pr[k] <= '0; end
    end else begin
      pv[0] <= o_eng_valid_pls;
      pr[0] <= dot(o_eng_vec1, o_eng_vec2);
      for (int k = 1; k < LAT; k++) begin pv[k] <= pv[k-1]; pr[k] <= pr[k-1]; end
    end
  end
  assign eng_vld = eng_on ? pv[LAT-1] : inj;
  assign eng_res = eng_on ? pr[LAT-1] : inj_res;

  // Reference model: outstanding IDs and expected results as queues
  int               qid[$];
  logic [RES_W-1:0] qres[$];
  int               m_ptr, g;
  bit               mdl_ok = 1'b0;
  logic             e_eng_valid, e_res_valid, e_busy, e_err;
  logic [VEC_W-1:0] e_vec1, e_vec2;
  logic [RES_W-1:0] e_res;
  logic [ID_W-1:0]  e_res_id;
  logic [NUM_REQ-1:0] e_gnt;

  task automatic mdl_reset();
    qid.delete(); qres.delete();
    m_ptr = NUM_REQ - 1;
    e_eng_valid = 1'b0; e_res_valid = 1'b0; e_busy = 1'b0; e_err = 1'b0;
    e_vec1 = '0; e_vec2 = '0; e_res = '0; e_res_id = '0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mdl_reset();
      mdl_ok = 1'b1;
    end else if (mdl_ok) begin
      chk("m_eng_valid", o_eng_valid_pls, e_eng_valid);
      chk("m_eng_vec1", o_eng_vec1, e_vec1);
      chk("m_eng_vec2", o_eng_vec2, e_vec2);
      chk("m_res_valid", o_res_valid_pls, e_res_valid);
      chk("m_res", o_res, e_res);
      chk("m_res_id", o_res_id, e_res_id);
      chk("m_busy", o_busy, e_busy);
      chk("m_err", o_err, e_err);
      g = -1;
      if (!sw_rst && qid.size() < MAX_OUT)
        for (int i = 1; i <= NUM_REQ; i++)
          if (g < 0 && vld[(m_ptr + i) % NUM_REQ]) g = (m_ptr + i) % NUM_REQ;
      e_gnt = '0;
      if (g >= 0) e_gnt[g] = 1'b1;
      chk("m_gnt", o_req_gnt, e_gnt);
      if (sw_rst) begin
        mdl_reset();
      end else begin
        e_res_valid = 1'b0;
        if (eng_vld && qid.size() == 0) e_err = 1'b1;
        else if (eng_vld) begin
          e_res_valid = 1'b1;
          e_res_id    = ID_W'(qid.pop_front());
          e_res       = eng_on ? qres[0] : eng_res;
          void'(qres.pop_front());
        end
        e_eng_valid = (g >= 0);
        if (g >= 0) begin
          m_ptr  = g;
          e_vec1 = v1[g*VEC_W +: VEC_W];
          e_vec2 = v2[g*VEC_W +: VEC_W];
          qid.push_back(g);
          qres.push_back(dot(e_vec1, e_vec2));
        end
        e_busy = (qid.size() != 0);
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic rand_vecs();
    for (int w = 0; w < NUM_REQ*VEC_W/32; w++) begin
      v1[w*32 +: 32] = $urandom;
      v2[w*32 +: 32] = $urandom;
    end
  endtask

  task automatic do_srst(input logic eon);
    tick(); sw_rst = 1'b1; vld = '0; inj = 1'b0; eng_on = eon;
    tick(); sw_rst = 1'b0;
  endtask

  int t0, lat, ng, nr, gid;
  bit got;
  logic [RES_W-1:0] s_res;
  logic [ID_W-1:0]  s_id;
  int ids [16];
  int exp_ids [8] = '{1, 2, 3, 0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1; sw_rst = 1'b0; vld = '0; inj = 1'b0; inj_res = '0; eng_on = 1'b1;
    v1 = '0; v2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_gnt", o_req_gnt, 4'b0000);
    chk("reset_busy", o_busy, 1'b0);
    chk("reset_err", o_err, 1'b0);
    chk("reset_res_valid", o_res_valid_pls, 1'b0);

    // Single request from requester 2, all elements 0.5
    tick(); rand_vecs(); vld = 4'b0100;
    for (int e = 0; e < ELEMS; e++) begin
      v1[2*VEC_W + e*EW +: EW] = 6'b010000;
      v2[2*VEC_W + e*EW +: EW] = 6'b010000;
    end
    @(negedge clk);
    chk("single_gnt", o_req_gnt, 4'b0100);
    t0 = cyc_n; got = 1'b0; lat = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick(); vld = '0;
      @(negedge clk);
      if (o_res_valid_pls) begin got = 1'b1; lat = cyc_n - t0; s_res = o_res; s_id = o_res_id; end
    end
    chk("single_found", got, 1'b1);
    chk("single_latency", lat, 9);
    chk("single_res", s_res, 43'h2000);
    chk("single_id", s_id, 2'd2);

    // Round robin with all requesters active
    do_srst(1'b1);
    for (int i = 0; i < 8; i++) begin
      tick(); vld = 4'b1111; rand_vecs();
      @(negedge clk);
      gid = -1;
      for (int b = 0; b < NUM_REQ; b++) if (o_req_gnt[b]) gid = b;
      chk("rr_gnt", gid, i % 4);
    end
    nr = 0;
    for (int k = 0; k < 30; k++) begin
      tick(); vld = '0;
      @(negedge clk);
      if (o_res_valid_pls && nr < 16) begin ids[nr] = o_res_id; nr++; end
    end
    chk("rr_res_count", nr, 8);
    for (int i = 0; i < 8; i++) chk("rr_res_id", ids[i], i % 4);

    // Full stall with a silent engine
    do_srst(1'b0);
    ng = 0;
    for (int k = 0; k < 12; k++) begin
      tick(); vld = 4'b1111; rand_vecs();
      @(negedge clk);
      if (o_req_gnt != '0) ng++;
    end
    chk("stall_grants", ng, 8);
    chk("stall_gnt_zero", o_req_gnt, 4'b0000);
    chk("stall_busy", o_busy, 1'b1);
    tick(); inj = 1'b1; inj_res = {$urandom, $urandom};
    @(negedge clk);
    chk("stall_gnt_in_pop", o_req_gnt, 4'b0000);
    tick(); inj = 1'b0;
    @(negedge clk);
    chk("stall_gnt_after_pop", o_req_gnt, 4'b0001);
    tick();
    @(negedge clk);
    chk("stall_full_again", o_req_gnt, 4'b0000);

    // Simultaneous grant and pop at three outstanding
    do_srst(1'b0);
    for (int k = 0; k < 3; k++) begin tick(); vld = 4'b1111; rand_vecs(); end
    tick(); vld = 4'b1111; rand_vecs(); inj = 1'b1; inj_res = {$urandom, $urandom};
    @(negedge clk);
    chk("sim_gnt", o_req_gnt, 4'b1000);
    ng = 0;
    for (int k = 0; k < 10; k++) begin
      tick(); inj = 1'b0; vld = 4'b1111; rand_vecs();
      @(negedge clk);
      if (o_req_gnt != '0) ng++;
    end
    chk("sim_more_grants", ng, 5);
    nr = 0;
    for (int k = 0; k < 10; k++) begin
      tick(); vld = '0; inj = (k < 8); inj_res = {$urandom, $urandom};
      @(negedge clk);
      if (o_res_valid_pls && nr < 16) begin ids[nr] = o_res_id; nr++; end
    end
    chk("sim_pop_count", nr, 8);
    for (int i = 0; i < 8; i++) chk("sim_order", ids[i], exp_ids[i]);
    chk("sim_err_clear", o_err, 1'b0);

    // Spurious engine pulse
    do_srst(1'b0);
    tick(); inj = 1'b1;
    tick(); inj = 1'b0;
    @(negedge clk);
    chk("spur_err", o_err, 1'b1);
    chk("spur_no_res", o_res_valid_pls, 1'b0);
    chk("spur_busy", o_busy, 1'b0);
    repeat (3) tick();
    @(negedge clk);
    chk("spur_sticky", o_err, 1'b1);
    do_srst(1'b0);
    @(negedge clk);
    chk("spur_cleared", o_err, 1'b0);

    // Mid-operation soft reset with five in flight
    do_srst(1'b0);
    ng = 0;
    for (int k = 0; k < 5; k++) begin
      tick(); vld = 4'b1111; rand_vecs();
      @(negedge clk);
      if (o_req_gnt != '0) ng++;
    end
    chk("mid_grants", ng, 5);
    tick(); sw_rst = 1'b1;
    @(negedge clk);
    chk("mid_gnt_in_srst", o_req_gnt, 4'b0000);
    tick(); sw_rst = 1'b0; vld = '0;
    @(negedge clk);
    chk("mid_busy", o_busy, 1'b0);
    chk("mid_eng_valid", o_eng_valid_pls, 1'b0);
    chk("mid_eng_vec1", o_eng_vec1, '0);
    chk("mid_res_valid", o_res_valid_pls, 1'b0);
    chk("mid_res", o_res, '0);
    chk("mid_res_id", o_res_id, '0);
    chk("mid_err", o_err, 1'b0);
`ifdef GEN_FIP_IP_ARB_STATS_EN
    for (int k = 0; k < 3; k++) begin tick(); vld = 4'b0010; end
    tick(); vld = '0;
    @(negedge clk);
    chk("stats_req1", gnt_cnt[31:16], 16'd3);
    chk("stats_req0", gnt_cnt[15:0], 16'd0);
`endif

    // Randomized traffic through the engine stub
    do_srst(1'b1);
    for (int k = 0; k < 500; k++) begin
      tick(); vld = NUM_REQ'($urandom); rand_vecs();
      sw_rst = ($urandom_range(0, 199) == 0);
    end
    for (int k = 0; k < 20; k++) begin tick(); vld = '0; sw_rst = 1'b0; end
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/gen_fip_inner_prod_arb.md
Name: gen_fip_inner_prod_arb

Overview:
- Round-robin arbiter sharing one pipelined inner-product engine (gen_fip_inner_prod) among NUM_REQ requesters.
- Accepts at most one vector pair per cycle and forwards it to the engine through registers.
- Tracks in-flight requester IDs in an ID FIFO and returns each engine result tagged with its requester ID.
- Sits between the consumer blocks (e.g. matrix-row sequencers) and the single engine instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- VEC_ELEMS_NUM, 32, elements per vector.
- ONE_ELEM_W, 6, bits per element (signed fixed point).
- RES_W, 43, engine result width.
- MAX_OUT, 8, maximum in-flight requests; ID FIFO depth; power of 2, must be at least engine latency + 1.
- SIM_DLY, 1, simulation delay on register assignments.
- ID_W, $clog2(NUM_REQ), local; requester ID width.
- VEC_W, VEC_ELEMS_NUM*ONE_ELEM_W, local.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- sw_rst  in  1  synchronous clear; same effect as rst.
- i_req_vld  in  NUM_REQ  per-requester request valid (level).
- i_req_vec1  in  NUM_REQ*VEC_W  packed vec1 operands; requester r occupies slice r.
- i_req_vec2  in  NUM_REQ*VEC_W  packed vec2 operands.
- o_req_gnt  out  NUM_REQ  one-hot grant; the request is accepted in this cycle.
- o_eng_valid_pls  out  1  pulse to engine i_valid_pls.
- o_eng_vec1  out  VEC_W  engine operand 1.
- o_eng_vec2  out  VEC_W  engine operand 2.
- i_eng_valid_pls  in  1  engine o_valid_pls.
- i_eng_res  in  RES_W  engine o_res.
- o_res_valid_pls  out  1  tagged result pulse.
- o_res  out  RES_W  result.
- o_res_id  out  ID_W  requester that owns o_res.
- o_busy  out  1  high when the outstanding count is non-zero.
- o_err  out  1  sticky flag: engine result arrived while the ID FIFO was empty.

Behaviour:
- Reset (rst or sw_rst): all outputs 0; round-robin pointer = NUM_REQ-1, so requester 0 has first priority; FIFO empty; outstanding count 0; o_err cleared.
- can_issue = (out_cnt < MAX_OUT), computed from registered state only.
- Grant:
  - Combinational. Picks the first requester with i_req_vld high, searching from pointer+1 upward with wrap; grants it only if can_issue.
  - At most one grant bit per cycle. o_req_gnt is 0 when no request is valid or when out_cnt == MAX_OUT.
  - The requester holds its vec slices stable during the grant cycle and may change them on the next cycle.
- Issue, grant at cycle T:
  - Pointer updates to the granted ID.
  - At T+1: o_eng_vec1/vec2 hold the granted slices and o_eng_valid_pls = 1 for one cycle.
  - The granted ID is pushed into the FIFO at T.
  - o_eng_vec1/vec2 hold their value when there is no issue.
- Return:
  - On i_eng_valid_pls, the FIFO pops.
  - Next cycle: o_res_valid_pls = 1, o_res = i_eng_res, o_res_id = popped ID.
  - End-to-end latency: grant at T gives o_res_valid_pls at T+2+L, where L is the engine latency (7 for defaults), so T+9.
  - Results return in issue order; no back-pressure on the result side.
- Outstanding count:
  - +1 on grant, -1 on pop; a simultaneous grant and pop leaves it unchanged.
  - A pop in the cycle when out_cnt == MAX_OUT does not enable a grant in that same cycle.
- Errors: i_eng_valid_pls with the FIFO empty sets o_err, produces no o_res_valid_pls, and leaves the count unchanged (no underflow).
- Reset mid-operation: in-flight IDs are discarded. Engine pulses that arrive after the reset set o_err; the integrator also resets the engine with the same sw_rst.
- FIFO pointers wrap modulo MAX_OUT.

Optional Feature:
- Macro GEN_FIP_IP_ARB_STATS_EN.
- When defined:
  - Adds output o_gnt_cnt, width NUM_REQ*16, packed.
  - Holds a per-requester 16-bit grant counter that saturates at 16'hFFFF.
  - Counters clear on rst/sw_rst.
- When not defined: the port and the counters are absent, and all other behaviour is identical.

Test Plan:
- Single request, engine instantiated, elements 6'b010000 (0.5). Requester 2, all 32 element pairs 0.5*0.5, grant at T -> o_gnt=4'b0100 at T; o_res_valid_pls at T+9; o_res=43'h2000 (8.0, 10 fraction bits); o_res_id=2.
- Round-robin. i_req_vld=4'b1111 held for 8 cycles -> grants 0,1,2,3,0,1,2,3 in order; results return tagged 0,1,2,3,0,1,2,3.
- Full stall. Stub engine that never answers, continuous requests -> exactly 8 grants, then o_req_gnt=0; o_busy=1. Injecting one i_eng_valid_pls -> one grant, no earlier than the cycle after the pop.
- Simultaneous grant and pop at out_cnt=3 -> out_cnt stays 3 and FIFO order is preserved.
- Spurious engine pulse at reset state -> o_err=1 and stays 1; no o_res_valid_pls. sw_rst -> o_err=0.
- Mid-operation sw_rst with 5 in flight -> next cycle o_busy=0 and all outputs 0. With GEN_FIP_IP_ARB_STATS_EN, 3 grants to requester 1 -> o_gnt_cnt[31:16]=3.
